booth_multiplier_seq: RTL and testbench

Iterative radix-4 Booth multiplier, parametrised in operand width, supporting signed and unsigned operands with valid/ready handshakes on both sides. It is the area-reduced sequential successor to our combinational 16x16 Booth/CSA multiplier. It retires one Booth digit per clock, so one adder replaces the partial-product array. It sits between operand-producing datapath stages and a consumer that may apply back-pressure.

---
 rtl/booth_multiplier_seq_if.sv | 36 +++
 rtl/booth_multiplier_seq.sv | 152 +++++++++++++++
 tb/tb_booth_multiplier_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_seq_if.sv
// Operand/product handshake bundle for booth_multiplier_seq.
// The producer and consumer sides both connect through the master modport.
interface booth_multiplier_seq_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 signed_mode;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   z;

   modport master (
      output in_valid,
      output signed_mode,
      output x,
      output y,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  z
   );

   modport slave (
      input  in_valid,
      input  signed_mode,
      input  x,
      input  y,
      input  out_ready,
      output in_ready,
      output out_valid,
      output z
   );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock through a single adder.
// Signed and unsigned operands share one signed datapath by extending both operands by two bits.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | in_ready=1, waiting for operands
//   S_BUSY | one Booth digit added and shifted per cycle, N cycles total
//   S_DONE | out_valid=1, z held until the consumer takes it
module booth_multiplier_seq #(
   parameter int WIDTH = 16
) (
   input logic                  clk,
   input logic                  reset_n,
   booth_multiplier_seq_if.slave bus
);

   localparam int N  = WIDTH/2 + 1;
   localparam int EW = WIDTH + 2;
   localparam int SW = WIDTH + 4;
   localparam int AW = 2*WIDTH + 4;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic [EW-1:0]        x_q;
   logic [AW-1:0]        acc_q;
   logic [AW-1:0]        acc_d;
   logic                 prev_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   z_q;

   logic                 accept;
   logic                 last_digit;
   logic [EW-1:0]        x_in_ext;
   logic [EW-1:0]        y_in_ext;
   logic [SW-1:0]        x_sext;
   logic [SW-1:0]        multiple;
   logic [SW-1:0]        addend;
   logic [SW-1:0]        sum;
   logic [SW-1:0]        carry_in;
   logic [SW-1:0]        upper_ext;
   logic                 negate;

   assign accept     = (state_q == S_IDLE) && bus.in_valid;
   assign last_digit = (cnt_q == CNT_LAST);

   assign x_in_ext = bus.signed_mode ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
   assign y_in_ext = bus.signed_mode ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (last_digit) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Digit window is {two lowest multiplier bits still in the accumulator, last bit shifted out}.
   always_comb begin
      x_sext   = {{2{x_q[EW-1]}}, x_q};
      multiple = '0;
      negate   = 1'b0;
      case ({acc_q[1:0], prev_q})
         3'b001, 3'b010: begin
            multiple = x_sext;
         end
         3'b011: begin
            multiple = x_sext << 1;
         end
         3'b100: begin
            multiple = x_sext << 1;
            negate   = 1'b1;
         end
         3'b101, 3'b110: begin
            multiple = x_sext;
            negate   = 1'b1;
         end
         default: begin
            multiple = '0;
         end
      endcase
      addend    = negate ? ~multiple : multiple;
      carry_in  = {{(SW-1){1'b0}}, negate};
      upper_ext = {{2{acc_q[AW-1]}}, acc_q[AW-1:EW]};
      sum       = upper_ext + addend + carry_in;
      // Arithmetic shift right by two of {sum, lower half}; the two guard bits of sum absorb the growth.
      acc_d     = {sum, acc_q[EW-1:2]};
   end

   // The lower half starts out holding the extended multiplier and fills with product bits as it shifts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q    <= '0;
         acc_q  <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
         z_q    <= '0;
      end else begin
         if (accept) begin
            x_q    <= x_in_ext;
            acc_q  <= {{EW{1'b0}}, y_in_ext};
            prev_q <= 1'b0;
            cnt_q  <= '0;
         end else if (state_q == S_BUSY) begin
            acc_q  <= acc_d;
            prev_q <= acc_q[1];
            cnt_q  <= cnt_q + CNT_ONE;
            if (last_digit) begin
               z_q <= acc_d[2*WIDTH-1:0];
            end
         end
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.z         = z_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: directed WIDTH=16 vectors and corner sequences,
// plus randomized traffic on WIDTH 4/8/16/32 checked against a plain-arithmetic product model.
module tb_booth_multiplier_seq;

   localparam int RAND_OPS = 600;

   logic clk = 1'b0;
   logic reset_n;
   logic rrst_n;
   int   checks = 0;
   int   errors = 0;
   int   rand_done = 0;

   always #5 clk = ~clk;

   booth_multiplier_seq_if #(.WIDTH(16)) d();
   booth_multiplier_seq #(.WIDTH(16)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (d.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Product of two w-bit operands interpreted per mode, reduced to 2*w bits.
   function automatic logic [63:0] ref_product(input int w, input bit m,
                                                input logic [31:0] a, input logic [31:0] b);
      longint     sa;
      longint     sb;
      logic [63:0] p;
      logic [63:0] mask;
      sa = longint'(a);
      sb = longint'(b);
      if (m && a[w-1]) sa = sa - (longint'(1) << w);
      if (m && b[w-1]) sb = sb - (longint'(1) << w);
      p    = 64'(sa * sb);
      mask = (64'd1 << (2*w)) - 64'd1;
      return p & mask;
   endfunction

   // ---------------- directed WIDTH=16 ----------------
   typedef struct {
      bit          m;
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] z;
   } vec_t;

   vec_t vecs[11];

   task automatic start_op(input bit m, input logic [15:0] a, input logic [15:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      d.signed_mode = m;
      d.x           = a;
      d.y           = b;
      d.in_valid    = 1'b1;
      while (!d.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!d.in_ready) check("accept_timeout", 64'(d.in_ready), 64'd1);
      @(posedge clk);
      #1;
      d.in_valid    = 1'b0;
      d.x           = 16'($urandom);
      d.y           = 16'($urandom);
      d.signed_mode = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!d.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin : directed
      int lat;
      bit ok;
      int guard;

      vecs[0]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
      vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
      vecs[3]  = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
      vecs[4]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
      vecs[5]  = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
      vecs[6]  = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};
      vecs[7]  = '{1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1};
      vecs[8]  = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF};
      vecs[9]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
      vecs[10] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};

      d.in_valid    = 1'b0;
      d.signed_mode = 1'b0;
      d.x           = '0;
      d.y           = '0;
      d.out_ready   = 1'b0;
      reset_n       = 1'b1;
      rrst_n        = 1'b1;
      #2;
      reset_n = 1'b0;
      rrst_n  = 1'b0;
      #1;
      check("reset_in_ready", 64'(d.in_ready), 64'd1);
      check("reset_out_valid", 64'(d.out_valid), 64'd0);
      check("reset_z", 64'(d.z), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rrst_n  = 1'b1;

      d.out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         start_op(vecs[i].m, vecs[i].x, vecs[i].y);
         wait_valid(lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
         check($sformatf("vec%0d_z", i), 64'(d.z), 64'(vecs[i].z));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_xfer_in_ready", i), 64'(d.in_ready), 64'd1);
         check($sformatf("vec%0d_xfer_out_valid", i), 64'(d.out_valid), 64'd0);
      end

      // back-pressure: product and state hold while the consumer stalls
      d.out_ready = 1'b0;
      start_op(1'b1, 16'h0003, 16'h0007);
      wait_valid(lat);
      check("bp_latency", 64'(lat), 64'd9);
      check("bp_z", 64'(d.z), 64'h15);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         d.in_valid = i[0];
         d.x        = 16'($urandom);
         d.y        = 16'($urandom);
         @(posedge clk);
         #1;
         if (d.z !== 32'h15 || d.out_valid !== 1'b1 || d.in_ready !== 1'b0) ok = 1'b0;
      end
      check("bp_hold", 64'(ok), 64'd1);
      @(negedge clk);
      d.in_valid  = 1'b0;
      d.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", 64'(d.out_valid), 64'd0);
      check("bp_release_in_ready", 64'(d.in_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("bp_not_queued_out_valid", 64'(d.out_valid), 64'd0);
      check("bp_not_queued_in_ready", 64'(d.in_ready), 64'd1);
      check("bp_z_kept", 64'(d.z), 64'h15);

      // asynchronous reset in the middle of an operation
      start_op(1'b1, 16'h1234, 16'h5678);
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_busy_in_ready", 64'(d.in_ready), 64'd1);
      check("rst_busy_out_valid", 64'(d.out_valid), 64'd0);
      check("rst_busy_z", 64'(d.z), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      start_op(1'b1, 16'h0003, 16'hFFFB);
      wait_valid(lat);
      check("after_rst_latency", 64'(lat), 64'd9);
      check("after_rst_z", 64'(d.z), 64'hFFFFFFF1);
      @(posedge clk);
      #1;

      guard = 0;
      while (rand_done < 4 && guard < 60000) begin
         @(posedge clk);
         guard++;
      end
      if (rand_done < 4) check("rand_finish", 64'(rand_done), 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- randomized, all widths in parallel ----------------
   for (genvar g = 0; g < 4; g++) begin : g_rand
      localparam int W = 4 << g;

      booth_multiplier_seq_if #(.WIDTH(W)) rb();
      booth_multiplier_seq #(.WIDTH(W)) u_rand (
         .clk     (clk),
         .reset_n (rrst_n),
         .bus     (rb.slave)
      );

      logic [63:0] expq[$];

      initial begin : producer
         int          guard;
         logic [31:0] a;
         logic [31:0] b;
         logic [31:0] wmask;
         bit          m;
         wmask          = 32'((64'd1 << W) - 64'd1);
         rb.in_valid    = 1'b0;
         rb.signed_mode = 1'b0;
         rb.x           = '0;
         rb.y           = '0;
         @(posedge rrst_n);
         for (int i = 0; i < RAND_OPS; i++) begin
            @(negedge clk);
            m = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
               0: a = 32'd0;
               1: a = 32'hFFFFFFFF;
               2: a = 32'd1 << (W-1);
               3: a = (32'd1 << (W-1)) - 32'd1;
               default: ;
            endcase
            case ($urandom_range(0, 7))
               0: b = 32'd0;
               1: b = 32'hFFFFFFFF;
               2: b = 32'd1 << (W-1);
               3: b = (32'd1 << (W-1)) - 32'd1;
               default: ;
            endcase
            a = a & wmask;
            b = b & wmask;
            rb.signed_mode = m;
            rb.x           = W'(a);
            rb.y           = W'(b);
            rb.in_valid    = 1'b1;
            guard = 0;
            while (!rb.in_ready && guard < 400) begin
               @(negedge clk);
               guard++;
            end
            if (!rb.in_ready) begin
               check($sformatf("rand_w%0d_accept_timeout", W), 64'(rb.in_ready), 64'd1);
               break;
            end
            expq.push_back(ref_product(W, m, a, b));
            @(posedge clk);
            #1;
            rb.in_valid    = 1'b0;
            rb.x           = W'($urandom);
            rb.y           = W'($urandom);
            rb.signed_mode = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      initial begin : consumer
         int          recv;
         int          idle;
         bit          r;
         logic [63:0] e;
         recv         = 0;
         idle         = 0;
         rb.out_ready = 1'b0;
         @(posedge rrst_n);
         while (recv < RAND_OPS && idle < 1000) begin
            @(negedge clk);
            r = ($urandom_range(0, 3) != 0);
            if (rb.out_valid && r) begin
               if (expq.size() == 0) begin
                  check($sformatf("rand_w%0d_spurious", W), 64'd1, 64'd0);
               end else begin
                  e = expq.pop_front();
                  check($sformatf("rand_w%0d_z", W), 64'(rb.z), e);
               end
               recv++;
               idle = 0;
            end else begin
               idle++;
            end
            rb.out_ready = r;
         end
         if (recv < RAND_OPS) check($sformatf("rand_w%0d_count", W), 64'(recv), 64'(RAND_OPS));
         rand_done++;
      end
   end

endmodule
